// File: rtl/turn_executor.sv
// turn_executor: line-follower node handler. Follows the line, accepts node
// markers, drives clear of the node, executes the turn requested by
// path_mapping and watches every turn state with a cycle timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FOLLOW   | steering from line sensors, waiting for an armed node marker
// CLEAR    | driving straight past the node for CLEAR_CYC cycles
// SPIN_OFF | spinning, blind period then waiting for centre sensor to leave line
// SPIN_ON  | spinning, waiting for centre sensor to reacquire a line
// FAULT    | turn timed out, motors stopped until reset
module turn_executor #(
   parameter int CLEAR_CYC   = 31250,
   parameter int BLIND_CYC   = 15625,
   parameter int TIMEOUT_CYC = 3125000
) (
   input  logic       clk_3125KHz,
   input  logic       reset,
   input  logic       node_flag,
   input  logic [1:0] turn_flag,
   input  logic       line_l,
   input  logic       line_c,
   input  logic       line_r,
   output logic       node_changed,
   output logic [2:0] motor_cmd,
   output logic       busy,
   output logic       fault,
   output logic [4:0] node_count
);

   typedef enum logic [2:0] {
      ST_FOLLOW   = 3'd0,
      ST_CLEAR    = 3'd1,
      ST_SPIN_OFF = 3'd2,
      ST_SPIN_ON  = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   localparam logic [2:0] CMD_STOP   = 3'd0;
   localparam logic [2:0] CMD_FWD    = 3'd1;
   localparam logic [2:0] CMD_VEER_L = 3'd2;
   localparam logic [2:0] CMD_VEER_R = 3'd3;
   localparam logic [2:0] CMD_SPIN_R = 3'd4;
   localparam logic [2:0] CMD_SPIN_L = 3'd5;

   localparam logic [1:0] TURN_STRAIGHT = 2'd0;
   localparam logic [1:0] TURN_UTURN    = 2'd2;
   localparam logic [1:0] TURN_LEFT     = 2'd3;

   // CLEAR ends on the edge where the counter shows CLEAR_CYC-1, giving
   // exactly CLEAR_CYC cycles of forward drive.
   localparam logic [21:0] CLEAR_LAST  = 22'(CLEAR_CYC - 1);
   localparam logic [21:0] BLIND_MIN   = 22'(BLIND_CYC);
   localparam logic [21:0] TIMEOUT_LIM = 22'(TIMEOUT_CYC);
   localparam logic [21:0] CNT_MAX     = '1;
   localparam logic [4:0]  COUNT_MAX   = '1;

   state_t      state_q, state_d;
   logic [21:0] cnt_q, cnt_d, cnt_inc;
   logic        armed_q, armed_d;
   logic        laps_q, laps_d;
   logic [1:0]  turn_q, turn_d;
   logic [2:0]  motor_q, motor_d;
   logic        node_changed_q, node_changed_d;
   logic [4:0]  node_count_q, node_count_d;
   logic [2:0]  steer_cmd;
   logic [2:0]  spin_cmd;

   // Sensor steering priority: centre, then left, then right.
   always_comb begin
      steer_cmd = CMD_STOP;
      if (line_c) begin
         steer_cmd = CMD_FWD;
      end else if (line_l) begin
         steer_cmd = CMD_VEER_L;
      end else if (line_r) begin
         steer_cmd = CMD_VEER_R;
      end
   end

   // Saturating counter increment and spin direction for the latched turn.
   always_comb begin
      cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 22'd1;
      spin_cmd = (turn_q == TURN_LEFT) ? CMD_SPIN_L : CMD_SPIN_R;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d        = state_q;
      armed_d        = armed_q;
      laps_d         = laps_q;
      turn_d         = turn_q;
      motor_d        = motor_q;
      node_changed_d = 1'b0;
      node_count_d   = node_count_q;
      cnt_d          = cnt_inc;

      case (state_q)
         ST_FOLLOW: begin
            motor_d = steer_cmd;
            if (armed_q && node_flag) begin
               // Node acceptance overrides steering for this cycle.
               state_d        = ST_CLEAR;
               armed_d        = 1'b0;
               node_changed_d = 1'b1;
               motor_d        = CMD_FWD;
               if (node_count_q != COUNT_MAX) begin
                  node_count_d = node_count_q + 5'd1;
               end
            end else if (!node_flag) begin
               armed_d = 1'b1;
            end
         end

         ST_CLEAR: begin
            motor_d = CMD_FWD;
            if (cnt_q >= CLEAR_LAST) begin
               // The only point at which turn_flag is looked at.
               turn_d = turn_flag;
               laps_d = 1'b0;
               if (turn_flag == TURN_STRAIGHT) begin
                  state_d = ST_FOLLOW;
                  motor_d = steer_cmd;
               end else begin
                  state_d = ST_SPIN_OFF;
                  motor_d = (turn_flag == TURN_LEFT) ? CMD_SPIN_L : CMD_SPIN_R;
               end
            end
         end

         ST_SPIN_OFF: begin
            motor_d = spin_cmd;
            if ((cnt_q >= BLIND_MIN) && !line_c) begin
               state_d = ST_SPIN_ON;
            end else if (cnt_inc >= TIMEOUT_LIM) begin
               state_d = ST_FAULT;
               motor_d = CMD_STOP;
            end
         end

         ST_SPIN_ON: begin
            motor_d = spin_cmd;
            if (line_c) begin
               if ((turn_q == TURN_UTURN) && !laps_q) begin
                  // First line crossed during a U-turn; spin on to the next.
                  laps_d  = 1'b1;
                  state_d = ST_SPIN_OFF;
               end else begin
                  laps_d  = 1'b0;
                  state_d = ST_FOLLOW;
                  motor_d = steer_cmd;
               end
            end else if (cnt_inc >= TIMEOUT_LIM) begin
               state_d = ST_FAULT;
               motor_d = CMD_STOP;
            end
         end

         ST_FAULT: begin
            motor_d = CMD_STOP;
         end

         default: begin
            state_d = ST_FAULT;
            motor_d = CMD_STOP;
         end
      endcase

      // Counter restarts on every state change and idles at zero outside turns.
      if ((state_d != state_q) || (state_q == ST_FOLLOW) || (state_q == ST_FAULT)) begin
         cnt_d = '0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_3125KHz) begin
      if (reset) begin
         state_q        <= ST_FOLLOW;
         cnt_q          <= '0;
         armed_q        <= 1'b0;
         laps_q         <= 1'b0;
         turn_q         <= TURN_STRAIGHT;
         motor_q        <= CMD_STOP;
         node_changed_q <= 1'b0;
         node_count_q   <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         armed_q        <= armed_d;
         laps_q         <= laps_d;
         turn_q         <= turn_d;
         motor_q        <= motor_d;
         node_changed_q <= node_changed_d;
         node_count_q   <= node_count_d;
      end
   end

   assign node_changed = node_changed_q;
   assign motor_cmd    = motor_q;
   assign busy         = (state_q != ST_FOLLOW);
   assign fault        = (state_q == ST_FAULT);
   assign node_count   = node_count_q;

endmodule

// File: tb/tb_turn_executor.sv
// Testbench for turn_executor with short timing parameters.
module tb_turn_executor;

   localparam int CLR  = 4;
   localparam int BLD  = 3;
   localparam int TMO  = 50;
   localparam int MAXN = 256;

   logic       clk = 1'b0;
   logic       reset;
   logic       node_flag;
   logic [1:0] turn_flag;
   logic       line_l, line_c, line_r;
   logic       node_changed;
   logic [2:0] motor_cmd;
   logic       busy, fault;
   logic [4:0] node_count;

   int tests = 0;
   int fails = 0;
   int exp_count = 0;
   bit lseq[MAXN];

   typedef struct {
      logic       l;
      logic       c;
      logic       r;
      logic [2:0] m;
   } vec_t;

   vec_t vt[8];

   turn_executor #(
      .CLEAR_CYC  (CLR),
      .BLIND_CYC  (BLD),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk_3125KHz (clk),
      .reset       (reset),
      .node_flag   (node_flag),
      .turn_flag   (turn_flag),
      .line_l      (line_l),
      .line_c      (line_c),
      .line_r      (line_r),
      .node_changed(node_changed),
      .motor_cmd   (motor_cmd),
      .busy        (busy),
      .fault       (fault),
      .node_count  (node_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] steer(input logic l, input logic c, input logic r);
      if (c) return 3'd1;
      if (l) return 3'd2;
      if (r) return 3'd3;
      return 3'd0;
   endfunction

   // Reference: given the line_c trace (index j = value present before the
   // j-th edge after acceptance), find the edge at which the turn ends.
   // Each spin lap is: after the blind time, the first off-line sample, then
   // the first on-line sample, each search bounded by the timeout window.
   function automatic void predict(input int turn, output int ev, output bit flt);
      int s;
      int j;
      int laps;
      flt = 1'b0;
      s   = CLR;
      ev  = CLR;
      if (turn == 0) return;
      laps = (turn == 2) ? 2 : 1;
      for (int n = 0; n < laps; n++) begin
         j = s + 1 + BLD;
         while ((j <= s + TMO) && lseq[j]) j++;
         if (j > s + TMO) begin
            ev  = s + TMO;
            flt = 1'b1;
            return;
         end
         s = j;
         j = s + 1;
         while ((j <= s + TMO) && !lseq[j]) j++;
         if (j > s + TMO) begin
            ev  = s + TMO;
            flt = 1'b1;
            return;
         end
         s = j;
      end
      ev = s;
   endfunction

   task automatic do_reset();
      reset     = 1'b1;
      node_flag = 1'b0;
      turn_flag = 2'd0;
      line_l    = 1'b0;
      line_c    = 1'b0;
      line_r    = 1'b0;
      tick();
      reset     = 1'b0;
      exp_count = 0;
   endtask

   task automatic accept_bump();
      if (exp_count < 31) exp_count++;
   endtask

   task automatic scenario(input int turn, input bit stuck);
      int         ev;
      int         last;
      int         j;
      int         len;
      bit         v;
      bit         flt;
      logic [2:0] em;
      node_flag = 1'b0;
      line_c    = 1'b1;
      line_l    = 1'b0;
      line_r    = 1'b0;
      tick();
      chk("arm_no_pulse", node_changed, 0);

      j = 0;
      while (j < MAXN) begin
         v   = 1'($urandom % 2);
         len = $urandom_range(1, 8);
         for (int k = 0; k < len && j < MAXN; k++) begin
            lseq[j] = v;
            j++;
         end
      end
      if (stuck) begin
         len = $urandom_range(CLR + 1, 30);
         for (int k = len; k < MAXN; k++) lseq[k] = 1'b0;
      end
      predict(turn, ev, flt);

      node_flag = 1'b1;
      line_c    = lseq[0];
      line_l    = 1'($urandom % 2);
      line_r    = 1'($urandom % 2);
      turn_flag = 2'($urandom % 4);
      tick();
      accept_bump();
      chk("acc_pulse", node_changed, 1);
      chk("acc_motor", motor_cmd, 1);
      chk("acc_busy", busy, 1);
      chk("acc_count", node_count, 32'(exp_count));

      last = ev + 3;
      for (int i = 1; i <= last; i++) begin
         line_c    = lseq[i];
         line_l    = 1'($urandom % 2);
         line_r    = 1'($urandom % 2);
         turn_flag = (i == CLR) ? 2'(turn) : 2'($urandom % 4);
         node_flag = (i < ev) ? 1'($urandom % 2) : 1'b1;
         tick();
         if (flt && i >= ev)  em = 3'd0;
         else if (i < CLR)    em = 3'd1;
         else if (i < ev)     em = (turn == 3) ? 3'd5 : 3'd4;
         else                 em = steer(line_l, line_c, line_r);
         chk("turn_motor", motor_cmd, 32'(em));
         chk("turn_busy", busy, 32'((i < ev) || flt));
         chk("turn_fault", fault, 32'(flt && (i >= ev)));
         chk("turn_no_pulse", node_changed, 0);
      end
      chk("turn_count", node_count, 32'(exp_count));
      if (flt) begin
         do_reset();
         chk("post_fault_clear", fault, 0);
      end
   endtask

   initial begin
      int pulses;
      vt[0] = '{1'b0, 1'b0, 1'b0, 3'd0};
      vt[1] = '{1'b0, 1'b0, 1'b1, 3'd3};
      vt[2] = '{1'b0, 1'b1, 1'b0, 3'd1};
      vt[3] = '{1'b0, 1'b1, 1'b1, 3'd1};
      vt[4] = '{1'b1, 1'b0, 1'b0, 3'd2};
      vt[5] = '{1'b1, 1'b0, 1'b1, 3'd2};
      vt[6] = '{1'b1, 1'b1, 1'b0, 3'd1};
      vt[7] = '{1'b1, 1'b1, 1'b1, 3'd1};

      // Reset state
      do_reset();
      reset = 1'b1;
      tick();
      chk("rst_motor", motor_cmd, 0);
      chk("rst_pulse", node_changed, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fault", fault, 0);
      chk("rst_count", node_count, 0);
      reset = 1'b0;

      // Steering table
      node_flag = 1'b0;
      for (int i = 0; i < 8; i++) begin
         line_l = vt[i].l;
         line_c = vt[i].c;
         line_r = vt[i].r;
         tick();
         chk("steer_motor", motor_cmd, 32'(vt[i].m));
         chk("steer_busy", busy, 0);
      end

      // Straight-through node
      do_reset();
      line_c = 1'b1;
      tick();
      tick();
      node_flag = 1'b1;
      tick();
      chk("s0_pulse", node_changed, 1);
      chk("s0_count", node_count, 1);
      node_flag = 1'b0;
      for (int i = 1; i < CLR; i++) begin
         tick();
         chk("s0_clear_motor", motor_cmd, 1);
         chk("s0_clear_busy", busy, 1);
         chk("s0_clear_pulse", node_changed, 0);
      end
      tick();
      chk("s0_follow_busy", busy, 0);
      chk("s0_follow_motor", motor_cmd, 1);
      chk("s0_follow_count", node_count, 1);

      // Right turn with line_c stuck low times out in SPIN_ON
      do_reset();
      line_c = 1'b1;
      tick();
      node_flag = 1'b1;
      tick();
      line_c = 1'b0;
      node_flag = 1'b0;
      turn_flag = 2'd1;
      for (int i = 1; i <= 58; i++) begin
         tick();
         if (i == 57) begin
            chk("to_pre_fault", fault, 0);
            chk("to_pre_motor", motor_cmd, 4);
         end
      end
      chk("to_fault", fault, 1);
      chk("to_motor", motor_cmd, 0);
      line_c = 1'b1;
      for (int i = 0; i < 10; i++) begin
         node_flag = ~node_flag;
         tick();
      end
      chk("to_hold_fault", fault, 1);
      chk("to_hold_motor", motor_cmd, 0);
      chk("to_hold_busy", busy, 1);
      chk("to_hold_count", node_count, 1);

      // Node held high for 100 cycles gives exactly one pulse
      do_reset();
      line_c = 1'b1;
      tick();
      node_flag = 1'b1;
      turn_flag = 2'd0;
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         pulses += int'(node_changed);
      end
      chk("hold_pulses", pulses, 1);
      chk("hold_count", node_count, 1);

      // Count saturation
      do_reset();
      pulses = 0;
      for (int i = 0; i < 33; i++) begin
         node_flag = 1'b0;
         tick();
         node_flag = 1'b1;
         tick();
         pulses += int'(node_changed);
         node_flag = 1'b0;
         repeat (5) tick();
         if (i == 30) chk("sat_count_31", node_count, 31);
      end
      chk("sat_pulses", pulses, 33);
      chk("sat_count", node_count, 31);

      // Reset mid-SPIN_ON with node held high
      do_reset();
      line_c = 1'b1;
      tick();
      node_flag = 1'b1;
      tick();
      turn_flag = 2'd1;
      line_c = 1'b0;
      for (int i = 1; i <= 10; i++) tick();
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      node_flag = 1'b1;
      tick();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_motor", motor_cmd, 0);
      chk("mid_rst_count", node_count, 0);
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         pulses += int'(node_changed);
      end
      chk("mid_no_accept", pulses, 0);
      node_flag = 1'b0;
      tick();
      node_flag = 1'b1;
      tick();
      chk("mid_reaccept", node_changed, 1);
      chk("mid_reaccept_count", node_count, 1);

      // Randomized turns against the reference
      do_reset();
      for (int n = 0; n < 40; n++) begin
         scenario($urandom % 4, ($urandom % 6) == 0);
      end
      scenario(2, 1'b0);
      scenario(3, 1'b0);
      scenario(1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/turn_executor.md
TURN_EXECUTOR -- requirements
Module: turn_executor

Interface
REQ-001 Parameter CLEAR_CYC, default 31250, cycles driven straight past a node before turning (10 ms at 3.125 MHz).
REQ-002 Parameter BLIND_CYC, default 15625, minimum spin cycles before the centre sensor is examined (5 ms).
REQ-003 Parameter TIMEOUT_CYC, default 3125000, maximum cycles in any turn state before fault (1 s); all parameters SHALL be at least 1 and at most 2^22-1.
REQ-004 clk_3125KHz  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 node_flag  in  1  level, high while the bot sits on a node marker.
REQ-007 turn_flag  in  2  turn from path_mapping: 0 straight, 1 right, 2 U-turn, 3 left.
REQ-008 line_l, line_c, line_r  in  1 each  thresholded line sensors, 1 = on line.
REQ-009 node_changed  out  1  one-cycle pulse to path_mapping on each accepted node.
REQ-010 motor_cmd  out  3  0 stop, 1 forward, 2 veer left, 3 veer right, 4 spin right, 5 spin left.
REQ-011 busy  out  1  high in every state except FOLLOW.
REQ-012 fault  out  1  high only in FAULT.
REQ-013 node_count  out  5  accepted nodes since reset; saturates at 31.

Function
REQ-014 States SHALL be FOLLOW, CLEAR, SPIN_OFF, SPIN_ON, FAULT; the encoding is free.
REQ-015 In FOLLOW, motor_cmd SHALL be registered from the sensors: line_c=1 gives 1; line_c=0 with line_l=1 gives 2; line_c=0, line_l=0 with line_r=1 gives 3; all zero gives 0.
REQ-016 Node acceptance requires node_flag=1 in FOLLOW and the armed flag set; armed SHALL set after node_flag is seen low for 1 cycle, and clear on acceptance.
REQ-017 On acceptance: node_changed=1 for exactly that following cycle, node_count increments (saturating), state becomes CLEAR, and the cycle counter clears.
REQ-018 In CLEAR, motor_cmd=1; after CLEAR_CYC cycles, turn_flag SHALL be sampled into an internal register and the counter cleared.
REQ-019 After sampling, turn 0 SHALL return to FOLLOW; turns 1 and 2 SHALL enter SPIN_OFF with motor_cmd=4; turn 3 SHALL enter SPIN_OFF with motor_cmd=5.
REQ-020 SPIN_OFF: hold the spin command; when counter >= BLIND_CYC and line_c=0, go to SPIN_ON.
REQ-021 SPIN_ON: hold the spin command until line_c=1.
  - Turns 1 and 3: the first line_c=1 completes the turn.
  - U-turn: a laps bit SHALL be set on the first line_c=1, the state returns to SPIN_OFF with the counter cleared, and the second line_c=1 completes the turn.
  - On completion: return to FOLLOW and clear the laps bit.
REQ-022 The turn counter SHALL be 22 bits, clear on every state change, and never wrap.
REQ-023 If the counter reaches TIMEOUT_CYC in SPIN_OFF or SPIN_ON, the state SHALL go to FAULT.
REQ-024 FAULT: motor_cmd=0, node_changed=0, fault=1; FAULT is left only by reset.
REQ-025 node_flag outside FOLLOW SHALL be ignored and SHALL NOT re-arm or count.
REQ-026 Simultaneous node acceptance and sensor steering in FOLLOW: acceptance wins and motor_cmd=1 on the next cycle.
REQ-027 turn_flag SHALL be read only at the REQ-018 sampling instant; changes at other times have no effect.

Reset
REQ-028 reset=1 at any edge, including mid-turn, SHALL force the following within one cycle:
  - state FOLLOW;
  - motor_cmd=0, node_changed=0, busy=0, fault=0, node_count=0;
  - counter and laps bit cleared;
  - armed cleared, so a node held across reset is not accepted until node_flag falls.
REQ-029 reset SHALL take priority over every other input.

Verification (bench with CLEAR_CYC=4, BLIND_CYC=3, TIMEOUT_CYC=50)
REQ-030 Reset, then line_c=1, node_flag low 2 cycles then high, turn_flag=0 -> node_changed pulses one cycle, motor_cmd=1 for 4 cycles, back to FOLLOW, node_count=1.
REQ-031 turn_flag=1 at node, line_c held 1 for 5 spin cycles then 0 for 2 then 1 -> motor_cmd=4 throughout SPIN_OFF/SPIN_ON, FOLLOW on the line_c=1 edge, busy falls.
REQ-032 turn_flag=2 with line_c pattern 1,0,1,0,1 spaced 4 cycles apart -> FOLLOW only after the second reacquisition; turn_flag=3 variant -> motor_cmd=5.
REQ-033 turn_flag=1 with line_c stuck 0 -> fault=1 and motor_cmd=0 after 50 SPIN_ON cycles; stays until reset.
REQ-034 node_flag held high for 100 cycles in FOLLOW -> exactly one node_changed pulse; 33 nodes accepted -> node_count=31.
REQ-035 reset asserted mid-SPIN_ON with node_flag=1 -> next cycle FOLLOW, motor_cmd=0; no acceptance until node_flag goes low then high.
